// File: rtl/pulse_delay_mc_if.sv
// pulse_delay_mc_if: trigger/config/status bundle for pulse_delay_mc
// master drives din/dly/len/mode/clr and observes dout/busy; slave is the reverse.
interface pulse_delay_mc_if #(
  parameter int CH = 4,
  parameter int CNT_W = 16
);
  logic [CH-1:0]    din;
  logic [CNT_W-1:0] dly;
  logic [CNT_W-1:0] len;
  logic             mode;
  logic             clr;
  logic [CH-1:0]    dout;
  logic [CH-1:0]    busy;
  modport master (output din, dly, len, mode, clr, input dout, busy);
  modport slave (input din, dly, len, mode, clr, output dout, busy);
endinterface

// File: rtl/pulse_delay_mc.sv
// pulse_delay_mc: independent per-channel rising-edge triggered delayed pulse generators
// Ports: clk; n_rst async active-low; bus (slave): din/dly/len/mode/clr in, dout/busy out.
module pulse_delay_mc #(
  parameter int CH = 4,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             n_rst,
  pulse_delay_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, PULSE} state_t;
  state_t           st_q [CH];
  state_t           st_d [CH];
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  logic [CNT_W-1:0] len_q [CH];
  logic [CNT_W-1:0] len_d [CH];
  logic [CH-1:0]    din_q, trig, dout_q, dout_d, busy_q, busy_d;
  assign trig = bus.din & ~din_q;
  always_comb begin
    dout_d = '0;
    busy_d = '0;
    for (int i = 0; i < CH; i++) begin
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i];
      len_d[i] = len_q[i];
      if (bus.clr) begin
        st_d[i] = IDLE;
        cnt_d[i] = '0;
      end else if (trig[i] && (st_q[i] == IDLE || bus.mode)) begin
        // len is kept so a WAIT can load the pulse length sampled at trigger time
        len_d[i] = bus.len;
        if (bus.len == '0) begin
          st_d[i] = IDLE;
          cnt_d[i] = '0;
        end else if (st_q[i] == PULSE || bus.dly == '0) begin
          // a retrigger during PULSE extends the pulse without a gap, ignoring dly
          st_d[i] = PULSE;
          cnt_d[i] = bus.len - CNT_W'(1);
        end else begin
          st_d[i] = WAIT;
          cnt_d[i] = bus.dly - CNT_W'(1);
        end
      end else if (st_q[i] != IDLE) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        else if (st_q[i] == WAIT) begin
          st_d[i] = PULSE;
          cnt_d[i] = len_q[i] - CNT_W'(1);
        end else st_d[i] = IDLE;
      end
      dout_d[i] = st_d[i] == PULSE;
      busy_d[i] = st_d[i] != IDLE;
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      din_q <= '0;
      dout_q <= '0;
      busy_q <= '0;
      for (int i = 0; i < CH; i++) begin
        st_q[i] <= IDLE;
        cnt_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      din_q <= bus.din;
      dout_q <= dout_d;
      busy_q <= busy_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end
  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
endmodule

// File: doc/pulse_delay_mc.md
PULSE_DELAY_MC -- requirements
Module: pulse_delay_mc

Interface
REQ-001 Parameter CH, default 4, number of independent channels (1..32).
REQ-002 Parameter CNT_W, default 16, width of delay/length counters (2..32).
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port n_rst  input  1  reset, asynchronous and active-low.
REQ-005 Port din  input  CH  per-channel trigger, synchronous to clk.
REQ-006 Port dly  input  CNT_W  cycles from trigger to pulse start, shared by all channels.
REQ-007 Port len  input  CNT_W  output pulse length in cycles, shared by all channels.
REQ-008 Port mode  input  1  0 = one-shot (triggers ignored while busy), 1 = retriggerable.
REQ-009 Port clr  input  1  synchronous abort of all channels.
REQ-010 Port dout  output  CH  per-channel delayed pulse.
REQ-011 Port busy  output  CH  per-channel, high while channel not IDLE.

Function
REQ-012 Per channel: registered copy din_d; trigger = din & ~din_d (rising edge only); level-held din SHALL NOT re-trigger.
REQ-013 Per channel FSM states IDLE, WAIT, PULSE; one CNT_W-bit down-counter per channel.
REQ-014 dly and len SHALL be sampled only at the edge a trigger is accepted; later changes do not affect the channel until its next accepted trigger.
REQ-015 IDLE + trigger, len=0: stay IDLE, no pulse, busy stays low.
REQ-016 IDLE + trigger, len>0, dly=0: -> PULSE, counter = len-1.
REQ-017 IDLE + trigger, len>0, dly>0: -> WAIT, counter = dly-1.
REQ-018 WAIT: counter decrements each cycle; at counter=0 -> PULSE with counter = len-1, len being the value sampled at trigger.
REQ-019 PULSE: counter decrements each cycle; at counter=0 -> IDLE.
REQ-020 dout = (state==PULSE), busy = (state!=IDLE), both from registered state, no combinational path from din.
REQ-021 Timing: trigger accepted at edge E0 -> dout high from E0+dly through the cycle before E0+dly+len; exactly len cycles high.
REQ-022 mode=0: triggers in WAIT or PULSE ignored.
REQ-023 mode=1, trigger in WAIT: restart WAIT with new dly/len (dly=0 -> PULSE immediately, len=0 -> IDLE).
REQ-024 mode=1, trigger in PULSE: stay PULSE, counter reloaded to len-1 (dout stays high, no gap); len=0 -> IDLE.
REQ-025 Trigger on the same edge a channel would return to IDLE is handled as a trigger in its current state per REQ-022..024.
REQ-026 clr=1: all channels -> IDLE, counters 0, on that edge; clr overrides any simultaneous trigger; din_d still updates so a din held high through clr does not trigger afterwards.
REQ-027 Channels fully independent; simultaneous triggers on any subset handled in the same cycle.
REQ-028 mode change takes effect on the next edge; a channel in progress is not aborted by it.
REQ-029 Counter arithmetic modulo 2^CNT_W never wraps: loads occur only from dly-1/len-1 with operand > 0.

Reset
REQ-030 n_rst low: immediately all states IDLE, counters 0, din_d 0, dout 0, busy 0, independent of clk.
REQ-031 Reset deassertion mid-pulse SHALL NOT resume the pulse; a din already high at deassertion counts as a rising edge on the first clock edge.

Verification
REQ-032 CH=4, dly=3, len=5, mode=0, single-cycle din[0] at E0 -> dout[0] high E0+3..E0+7, busy[0] E0..E0+7, other dout low.
REQ-033 dly=0, len=1, din[2] held high 10 cycles -> exactly one 1-cycle dout[2] pulse starting E0.
REQ-034 mode=1, dly=2, len=4, retrigger din[1] at E0+4 (in PULSE) -> dout[1] continuously high E0+2..E0+7, low at E0+8; same stimulus mode=0 -> low at E0+6.
REQ-035 len=0 trigger -> no dout, busy stays 0; then clr asserted during PULSE on channels 0..3 -> all dout/busy low next edge, simultaneous trigger ignored.
REQ-036 n_rst pulled low mid-WAIT between clock edges -> dout/busy 0 immediately; after release, no pulse without a new rising edge.
REQ-037 CNT_W=4, dly=15, len=15 -> dout high exactly 15 cycles starting E0+15, no counter wrap.
